// File: rtl/ext_mem_server.sv
// Handle-addressed memory server: descriptors {valid, base, mask} map a
// handle plus word offset onto a single-port memory with 2-cycle latency.
module ext_mem_server #(
  parameter int data_width   = 16,
  parameter int handle_width = 8,
  parameter int n_handles    = 16,
  parameter int addr_width   = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    read_req,
  input  logic                    write_req,
  input  logic [handle_width-1:0] handle,
  input  logic [data_width-1:0]   arg_a,
  input  logic [data_width-1:0]   arg_b,
  output logic [data_width-1:0]   data_out,
  output logic                    read_valid,
  output logic                    write_ack,
  input  logic                    cfg_write,
  input  logic [handle_width-1:0] cfg_handle,
  input  logic [addr_width-1:0]   cfg_base,
  input  logic [addr_width-1:0]   cfg_mask,
  input  logic                    cfg_valid,
  output logic [1:0]              state_dbg_o
);

  localparam int IDX_W = (n_handles > 1) ? $clog2(n_handles) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                  state_q;
  logic                    op_write_q;
  logic                    dvalid_q;
  logic [addr_width-1:0]   addr_q;
  logic [data_width-1:0]   wdata_q;
  logic [data_width-1:0]   data_out_q;
  logic                    read_valid_q;
  logic                    write_ack_q;

  logic [n_handles-1:0]    desc_valid_q;
  logic [addr_width-1:0]   desc_base_q [n_handles];
  logic [addr_width-1:0]   desc_mask_q [n_handles];
  logic [data_width-1:0]   mem_q [2**addr_width];

  logic [IDX_W-1:0]        req_idx;
  logic [IDX_W-1:0]        cfg_idx;
  logic [addr_width-1:0]   addr_d;
  logic                    unused_bits;

  assign req_idx     = handle[IDX_W-1:0];
  assign cfg_idx     = cfg_handle[IDX_W-1:0];
  assign addr_d      = desc_base_q[req_idx] + (arg_a[addr_width-1:0] & desc_mask_q[req_idx]);
  assign unused_bits = ^{handle, cfg_handle, arg_a};

  // Descriptor table updates on every edge, independent of enable; a lookup
  // on the same edge sees the old entry because both use registered values.
  always_ff @(posedge clk) begin
    if (reset) begin
      desc_valid_q <= '0;
    end else if (cfg_write) begin
      desc_valid_q[cfg_idx] <= cfg_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (cfg_write) begin
      desc_base_q[cfg_idx] <= cfg_base;
      desc_mask_q[cfg_idx] <= cfg_mask;
    end
  end

  // Handshake: read_req/write_req are levels held until the one-cycle
  // read_valid/write_ack pulse; requests are only sampled in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      op_write_q   <= 1'b0;
      dvalid_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      data_out_q   <= '0;
      read_valid_q <= 1'b0;
      write_ack_q  <= 1'b0;
    end else if (enable) begin
      case (state_q)
        IDLE: begin
          read_valid_q <= 1'b0;
          write_ack_q  <= 1'b0;
          if (read_req || write_req) begin
            op_write_q <= write_req;
            dvalid_q   <= desc_valid_q[req_idx];
            addr_q     <= addr_d;
            wdata_q    <= arg_b;
            state_q    <= ACCESS;
          end
        end
        ACCESS: begin
          if (op_write_q) begin
            write_ack_q <= 1'b1;
          end else begin
            read_valid_q <= 1'b1;
            data_out_q   <= dvalid_q ? mem_q[addr_q] : '0;
          end
          state_q <= RESP;
        end
        RESP: begin
          read_valid_q <= 1'b0;
          write_ack_q  <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Memory is never reset; a reset edge in ACCESS suppresses the pending write.
  always_ff @(posedge clk) begin
    if (!reset && enable && state_q == ACCESS && op_write_q && dvalid_q) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

  assign data_out    = data_out_q;
  assign read_valid  = read_valid_q;
  assign write_ack   = write_ack_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_ext_mem_server.sv
// Self-checking bench for ext_mem_server: vector table plus hand-written
// stall, same-edge config and reset-abandon sequences, with a pulse scoreboard.
module tb_ext_mem_server;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        read_req;
  logic        write_req;
  logic [7:0]  handle;
  logic [15:0] arg_a;
  logic [15:0] arg_b;
  logic [15:0] data_out;
  logic        read_valid;
  logic        write_ack;
  logic        cfg_write;
  logic [7:0]  cfg_handle;
  logic [9:0]  cfg_base;
  logic [9:0]  cfg_mask;
  logic        cfg_valid;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  logic cfg_same_edge = 1'b0;
  logic [16:0] exp_q[$];

  ext_mem_server dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .read_req    (read_req),
    .write_req   (write_req),
    .handle      (handle),
    .arg_a       (arg_a),
    .arg_b       (arg_b),
    .data_out    (data_out),
    .read_valid  (read_valid),
    .write_ack   (write_ack),
    .cfg_write   (cfg_write),
    .cfg_handle  (cfg_handle),
    .cfg_base    (cfg_base),
    .cfg_mask    (cfg_mask),
    .cfg_valid   (cfg_valid),
    .state_dbg_o (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: every completion pulse pops one expected {is_write, data}
  always @(negedge clk) begin
    if (!reset && (read_valid || write_ack)) begin
      check("pulse_exclusive", {31'b0, read_valid & write_ack}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got rv=%0b wa=%0b expected none", read_valid, write_ack);
      end else begin
        check("scoreboard", {15'b0, write_ack, (read_valid ? data_out : 16'h0)},
              {15'b0, exp_q.pop_front()});
      end
    end
  end

  // driver tasks
  task automatic cfg(input logic [7:0] h, input logic [9:0] base, input logic [9:0] mask,
                     input logic v);
    @(negedge clk);
    cfg_write = 1'b1; cfg_handle = h; cfg_base = base; cfg_mask = mask; cfg_valid = v;
    @(negedge clk);
    cfg_write = 1'b0;
  endtask

  task automatic do_op(input logic wr, input logic rd, input logic [7:0] h,
                       input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp_d);
    @(negedge clk);
    write_req = wr; read_req = rd; handle = h; arg_a = a; arg_b = b;
    if (cfg_same_edge) cfg_write = 1'b1;
    exp_q.push_back({wr, (wr ? 16'h0 : exp_d)});
    @(negedge clk);
    cfg_write = 1'b0;
    cfg_same_edge = 1'b0;
    check("no_early_pulse", {30'b0, read_valid, write_ack}, 32'd0);
    check("access_state", {30'b0, state_dbg}, 32'd1);
    @(negedge clk);
    check("latency_pulse", {31'b0, (wr ? write_ack : read_valid)}, 32'd1);
    @(negedge clk);
    read_req = 1'b0; write_req = 1'b0;
    check("single_pulse", {30'b0, read_valid, write_ack}, 32'd0);
    check("idle_after", {30'b0, state_dbg}, 32'd0);
  endtask

  typedef struct {
    logic        wr;
    logic        rd;
    logic [7:0]  h;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_d;
  } vec_t;

  vec_t vecs[18];

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 8'd3, 16'h0005, 16'h1234, 16'h0000};
    vecs[1]  = '{1'b0, 1'b1, 8'd3, 16'h0015, 16'h0000, 16'h1234};
    vecs[2]  = '{1'b1, 1'b0, 8'd1, 16'h0006, 16'hBEEF, 16'h0000};
    vecs[3]  = '{1'b0, 1'b1, 8'd1, 16'h0006, 16'h0000, 16'hBEEF};
    vecs[4]  = '{1'b0, 1'b1, 8'd5, 16'h0002, 16'h0000, 16'hBEEF};
    vecs[5]  = '{1'b0, 1'b1, 8'd5, 16'h0105, 16'h0000, 16'h1234};
    vecs[6]  = '{1'b1, 1'b0, 8'd5, 16'h0050, 16'hA5A5, 16'h0000};
    vecs[7]  = '{1'b0, 1'b1, 8'd7, 16'h0050, 16'h0000, 16'h0000};
    vecs[8]  = '{1'b1, 1'b0, 8'd7, 16'h0050, 16'hFFFF, 16'h0000};
    vecs[9]  = '{1'b0, 1'b1, 8'd5, 16'h0050, 16'h0000, 16'hA5A5};
    vecs[10] = '{1'b1, 1'b0, 8'd3, 16'h001F, 16'h0F0F, 16'h0000};
    vecs[11] = '{1'b0, 1'b1, 8'd5, 16'h010F, 16'h0000, 16'h0F0F};
    vecs[12] = '{1'b1, 1'b1, 8'd5, 16'h0060, 16'h7777, 16'h0000};
    vecs[13] = '{1'b0, 1'b1, 8'd5, 16'h0060, 16'h0000, 16'h7777};
    vecs[14] = '{1'b1, 1'b0, 8'd5, 16'h0203, 16'h2222, 16'h0000};
    vecs[15] = '{1'b1, 1'b0, 8'd5, 16'h0003, 16'h3333, 16'h0000};
    vecs[16] = '{1'b1, 1'b0, 8'd5, 16'h0070, 16'h1111, 16'h0000};
    vecs[17] = '{1'b0, 1'b1, 8'd2, 16'h0003, 16'h0000, 16'h3333};

    reset = 1'b1; enable = 1'b1; read_req = 1'b0; write_req = 1'b0;
    handle = '0; arg_a = '0; arg_b = '0;
    cfg_write = 1'b0; cfg_handle = '0; cfg_base = '0; cfg_mask = '0; cfg_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_read_valid", {31'b0, read_valid}, 32'd0);
    check("reset_write_ack", {31'b0, write_ack}, 32'd0);
    check("reset_data_out", {16'b0, data_out}, 32'd0);
    check("reset_state", {30'b0, state_dbg}, 32'd0);

    cfg(8'd3, 10'h100, 10'h00F, 1'b1);
    cfg(8'd1, 10'h3FC, 10'h007, 1'b1);
    cfg(8'd5, 10'h000, 10'h3FF, 1'b1);
    cfg(8'd2, 10'h000, 10'h3FF, 1'b1);
    cfg(8'd7, 10'h000, 10'h3FF, 1'b0);

    for (int i = 0; i < 18; i++) begin
      do_op(vecs[i].wr, vecs[i].rd, vecs[i].h, vecs[i].a, vecs[i].b, vecs[i].exp_d);
    end

    // same-edge config: request on slot 2 still uses old base 0x000
    cfg_handle = 8'd2; cfg_base = 10'h200; cfg_mask = 10'h3FF; cfg_valid = 1'b1;
    cfg_same_edge = 1'b1;
    do_op(1'b0, 1'b1, 8'd2, 16'h0003, 16'h0000, 16'h3333);
    do_op(1'b0, 1'b1, 8'd2, 16'h0003, 16'h0000, 16'h2222);

    // enable stalled for 3 cycles while in ACCESS
    @(negedge clk);
    read_req = 1'b1; handle = 8'd3; arg_a = 16'h0005;
    exp_q.push_back({1'b0, 16'h1234});
    @(negedge clk);
    enable = 1'b0;
    check("stall_no_pulse", {30'b0, read_valid, write_ack}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_hold_pulse", {30'b0, read_valid, write_ack}, 32'd0);
      check("stall_hold_state", {30'b0, state_dbg}, 32'd1);
      if (i == 2) enable = 1'b1;
    end
    @(negedge clk);
    check("stall_late_pulse", {31'b0, read_valid}, 32'd1);
    @(negedge clk);
    read_req = 1'b0;
    check("stall_single_pulse", {31'b0, read_valid}, 32'd0);
    @(negedge clk);
    check("stall_no_repeat", {31'b0, read_valid}, 32'd0);

    // reset during ACCESS of a write abandons it
    @(negedge clk);
    write_req = 1'b1; handle = 8'd5; arg_a = 16'h0070; arg_b = 16'h9999;
    @(negedge clk);
    check("abandon_in_access", {30'b0, state_dbg}, 32'd1);
    reset = 1'b1; write_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("abandon_state_idle", {30'b0, state_dbg}, 32'd0);
    check("abandon_no_ack", {31'b0, write_ack}, 32'd0);
    @(negedge clk);
    check("abandon_no_late_ack", {30'b0, read_valid, write_ack}, 32'd0);
    do_op(1'b0, 1'b1, 8'd5, 16'h0070, 16'h0000, 16'h0000);
    do_op(1'b0, 1'b1, 8'd3, 16'h0005, 16'h0000, 16'h0000);
    cfg(8'd5, 10'h000, 10'h3FF, 1'b1);
    do_op(1'b0, 1'b1, 8'd5, 16'h0070, 16'h0000, 16'h1111);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
